// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
// Size codes follow the core's funct3 encoding; widths and FSM state live here.
package lsu_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned CNT_W    = 16;

  localparam logic [FUNCT3_W-1:0] SIZE_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] SIZE_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] SIZE_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] SIZE_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align_check.sv
// Combinational legality check of a core request: size code versus direction
// and natural alignment of the low address bits.
module lsu_align_check
  import lsu_pkg::*;
(
  input  logic [FUNCT3_W-1:0] i_funct3,
  input  logic [1:0]          i_addr_lo,
  input  logic                i_we,
  output logic                o_legal_c
);

  // Zero-extending sizes only make sense for loads.
  always_comb begin
    o_legal_c = 1'b0;
    case (i_funct3)
      SIZE_B:  o_legal_c = 1'b1;
      SIZE_BU: o_legal_c = !i_we;
      SIZE_H:  o_legal_c = !i_addr_lo[0];
      SIZE_HU: o_legal_c = !i_we && !i_addr_lo[0];
      SIZE_W:  o_legal_c = (i_addr_lo == 2'b00);
      default: o_legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-beat pipelined Wishbone initiator for the core.
// Optional bus timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  input  logic                i_req_we,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_data,
  input  logic [FUNCT3_W-1:0] i_req_funct3,
  output logic                o_req_ready,
  output logic                o_resp_valid,
  output logic [DATA_W-1:0]   o_resp_data,
  output logic                o_resp_err,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [ADDR_W-1:0]   o_wb_addr,
  output logic [DATA_W-1:0]   o_wb_data,
  output logic [FUNCT3_W-1:0] o_wb_sel,
  input  logic [DATA_W-1:0]   i_wb_data,
  input  logic                i_wb_ack,
  input  logic                i_wb_stall
);

  lsu_state_e          r_state;
  lsu_state_e          w_state_next;
  logic                w_legal;
  logic                w_timeout;
  logic                w_resp_err_next;
  logic [DATA_W-1:0]   w_resp_data_next;

  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic                r_resp_err;
  logic                r_wb_stb;
  logic                r_wb_we;
  logic [ADDR_W-1:0]   r_wb_addr;
  logic [DATA_W-1:0]   r_wb_data;
  logic [FUNCT3_W-1:0] r_wb_sel;

  lsu_align_check u_align_check (
    .i_funct3  (i_req_funct3),
    .i_addr_lo (i_req_addr[1:0]),
    .i_we      (i_req_we),
    .o_legal_c (w_legal)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // A valid ack always beats a timeout in the same cycle.
  always_comb begin
    w_state_next     = r_state;
    w_resp_err_next  = 1'b0;
    w_resp_data_next = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          if (w_legal) begin
            w_state_next = ST_REQ;
          end else begin
            w_state_next    = ST_RESP;
            w_resp_err_next = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (!i_wb_stall && i_wb_ack) begin
          w_state_next     = ST_RESP;
          w_resp_data_next = r_wb_we ? '0 : i_wb_data;
        end else if (w_timeout) begin
          w_state_next    = ST_RESP;
          w_resp_err_next = 1'b1;
        end else if (!i_wb_stall) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_wb_ack) begin
          w_state_next     = ST_RESP;
          w_resp_data_next = r_wb_we ? '0 : i_wb_data;
        end else if (w_timeout) begin
          w_state_next    = ST_RESP;
          w_resp_err_next = 1'b1;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_wb_stb     <= 1'b0;
      r_wb_we      <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_wb_sel     <= '0;
    end else begin
      r_req_ready  <= (w_state_next == ST_IDLE);
      r_resp_valid <= (w_state_next == ST_RESP);
      r_resp_data  <= w_resp_data_next;
      r_resp_err   <= w_resp_err_next;
      r_wb_stb     <= (w_state_next == ST_REQ);
      if (r_state == ST_IDLE && i_req_valid && w_legal) begin
        r_wb_we   <= i_req_we;
        r_wb_addr <= i_req_addr;
        r_wb_data <= i_req_data;
        r_wb_sel  <= i_req_funct3;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_busy;

  assign w_busy = (r_state == ST_REQ) || (r_state == ST_WAIT);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                              r_cnt <= '0;
    else if (w_state_next == ST_REQ && r_state != ST_REQ)     r_cnt <= '0;
    else if (w_busy)                                          r_cnt <= r_cnt + CNT_W'(1);
  end

  assign w_timeout = w_busy && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_err   = r_resp_err;
  assign o_wb_stb     = r_wb_stb;
  assign o_wb_we      = r_wb_we;
  assign o_wb_addr    = r_wb_addr;
  assign o_wb_data    = r_wb_data;
  assign o_wb_sel     = r_wb_sel;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: per-cycle expectations from a transaction timeline model,
// checked every cycle on the falling edge, plus literal latency/data pins.
module tb_lsu;

  localparam int unsigned TO = 8;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_data;
  logic [2:0]  i_req_funct3;
  logic        o_req_ready;
  logic        o_resp_valid;
  logic [31:0] o_resp_data;
  logic        o_resp_err;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [2:0]  o_wb_sel;
  logic [31:0] i_wb_data;
  logic        i_wb_ack;
  logic        i_wb_stall;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .i_req_we     (i_req_we),
    .i_req_addr   (i_req_addr),
    .i_req_data   (i_req_data),
    .i_req_funct3 (i_req_funct3),
    .o_req_ready  (o_req_ready),
    .o_resp_valid (o_resp_valid),
    .o_resp_data  (o_resp_data),
    .o_resp_err   (o_resp_err),
    .o_wb_stb     (o_wb_stb),
    .o_wb_we      (o_wb_we),
    .o_wb_addr    (o_wb_addr),
    .o_wb_data    (o_wb_data),
    .o_wb_sel     (o_wb_sel),
    .i_wb_data    (i_wb_data),
    .i_wb_ack     (i_wb_ack),
    .i_wb_stall   (i_wb_stall)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_tot  = 0;
  int n_pass = 0;
  int rv_cnt = 0;
  int stb_cnt = 0;

  // Expected outputs for the current cycle
  bit          cmp_en = 1'b0;
  logic        e_ready, e_stb, e_rv, e_err, e_wchk, e_we;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [2:0]  e_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge i_clk) begin
    if (o_resp_valid) rv_cnt <= rv_cnt + 1;
    if (o_wb_stb)     stb_cnt <= stb_cnt + 1;
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("req_ready", 32'(o_req_ready), 32'(e_ready));
      chk("wb_stb", 32'(o_wb_stb), 32'(e_stb));
      chk("resp_valid", 32'(o_resp_valid), 32'(e_rv));
      if (e_rv) begin
        chk("resp_err", 32'(o_resp_err), 32'(e_err));
        chk("resp_data", o_resp_data, e_rdata);
      end
      if (e_wchk) begin
        chk("wb_we", 32'(o_wb_we), 32'(e_we));
        chk("wb_addr", o_wb_addr, e_addr);
        chk("wb_data", o_wb_data, e_wdata);
        chk("wb_sel", 32'(o_wb_sel), 32'(e_sel));
      end
    end
  end

  // Legal iff size is known, zero-extend is load-only, and address is size-aligned.
  function automatic bit model_legal(input bit we, input bit [2:0] f3, input bit [31:0] addr);
    int sz;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        return 1'b0;
    endcase
    if (we && f3[2]) return 1'b0;
    return (addr % sz) == 0;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_idle();
    e_ready = 1'b1; e_stb = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_rdata = '0;
  endtask

  // One request; n_stall stalled strobe cycles, then ack after n_wait WAIT cycles (0 = same cycle).
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input int n_stall, input int n_wait,
                         input logic [31:0] rdata, output int resp_cyc);
    int c0;
    bit legal;
    legal = model_legal(we, f3, addr);
    c0 = cyc;
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_data = wdata; i_req_funct3 = f3;
    set_idle();
    step();
    i_req_valid = 1'b0; i_req_addr = ~addr; i_req_data = ~wdata; i_req_we = ~we;
    if (!legal) begin
      e_ready = 1'b0; e_rv = 1'b1; e_err = 1'b1; e_rdata = '0;
      resp_cyc = cyc - c0;
      step();
    end else begin
      e_wchk = 1'b1; e_we = we; e_addr = addr; e_wdata = wdata; e_sel = f3;
      e_ready = 1'b0; e_stb = 1'b1;
      for (int i = 0; i < n_stall; i++) begin
        i_wb_stall = 1'b1;
        step();
      end
      i_wb_stall = 1'b0;
      i_wb_data = ~rdata;
      if (n_wait == 0) begin i_wb_ack = 1'b1; i_wb_data = rdata; end
      step();
      i_wb_ack = 1'b0; i_wb_data = ~rdata; e_stb = 1'b0;
      for (int i = 1; i <= n_wait; i++) begin
        if (i == n_wait) begin i_wb_ack = 1'b1; i_wb_data = rdata; end
        step();
        i_wb_ack = 1'b0; i_wb_data = ~rdata;
      end
      e_rv = 1'b1; e_err = 1'b0; e_rdata = we ? 32'h0 : rdata;
      resp_cyc = cyc - c0;
      step();
    end
    set_idle();
  endtask

  initial begin
    int rc;
    int s0, r0;
    i_reset = 1'b1;
    i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0; i_req_data = '0; i_req_funct3 = '0;
    i_wb_data = '0; i_wb_ack = 1'b0; i_wb_stall = 1'b0;
    set_idle();
    e_wchk = 1'b1; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_sel = '0;
    cmp_en = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    step();

    // Word load, no stall, ack in cycle 2
    run_txn(1'b0, 32'h100, 32'h0, 3'b010, 0, 1, 32'hDEADBEEF, rc);
    chk("word_load_latency", 32'(rc), 32'd3);
    chk("word_load_data_lit", e_addr, 32'h100);

    // Stall hold: store word, three stall cycles
    s0 = stb_cnt; r0 = rv_cnt;
    run_txn(1'b1, 32'h204, 32'h12345678, 3'b010, 3, 1, 32'hCAFEF00D, rc);
    step();
    chk("stall_latency", 32'(rc), 32'd6);
    chk("stall_stb_cycles", 32'(stb_cnt - s0), 32'd4);
    chk("stall_single_resp", 32'(rv_cnt - r0), 32'd1);

    // Misaligned half load and illegal store size
    s0 = stb_cnt;
    run_txn(1'b0, 32'h101, 32'h0, 3'b001, 0, 1, 32'h0, rc);
    chk("misalign_latency", 32'(rc), 32'd1);
    run_txn(1'b1, 32'h100, 32'hAAAA5555, 3'b100, 0, 1, 32'h0, rc);
    chk("store_bu_latency", 32'(rc), 32'd1);
    chk("illegal_no_stb", 32'(stb_cnt - s0), 32'd0);

    // Same-cycle ack, zero-extend byte load at odd address
    run_txn(1'b0, 32'h103, 32'h0, 3'b100, 0, 0, 32'h000000A5, rc);
    chk("same_cycle_latency", 32'(rc), 32'd2);

    // Mixed patterns, back to back
    run_txn(1'b0, 32'h2, 32'h0, 3'b101, 1, 2, 32'h0000BEEF, rc);
    chk("hu_stall_wait_latency", 32'(rc), 32'd5);
    run_txn(1'b1, 32'h7, 32'h000000FF, 3'b000, 0, 0, 32'h11111111, rc);
    run_txn(1'b1, 32'h3, 32'h0000FFFF, 3'b001, 0, 1, 32'h0, rc);
    run_txn(1'b0, 32'h10, 32'h0, 3'b011, 0, 1, 32'h0, rc);
    run_txn(1'b0, 32'h102, 32'h0, 3'b010, 0, 1, 32'h0, rc);
    run_txn(1'b1, 32'h8, 32'h0, 3'b101, 0, 1, 32'h0, rc);
    run_txn(1'b0, 32'hFFFFFFFC, 32'h0, 3'b010, 2, 0, 32'h89ABCDEF, rc);
    chk("stall_same_ack_latency", 32'(rc), 32'd4);

    // Stray acks while idle are ignored
    r0 = rv_cnt;
    i_wb_ack = 1'b1; i_wb_data = 32'h55555555;
    step();
    step();
    i_wb_ack = 1'b0;
    step();
    chk("stray_ack_idle", 32'(rv_cnt - r0), 32'd0);

`ifdef LSU_TIMEOUT_EN
    // Timeout: never ack
    r0 = rv_cnt;
    s0 = cyc;
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h400; i_req_data = '0; i_req_funct3 = 3'b010;
    step();
    i_req_valid = 1'b0;
    e_wchk = 1'b1; e_we = 1'b0; e_addr = 32'h400; e_wdata = '0; e_sel = 3'b010;
    e_ready = 1'b0; e_stb = 1'b1;
    step();
    e_stb = 1'b0;
    for (int i = 0; i < int'(TO) - 1; i++) step();
    e_rv = 1'b1; e_err = 1'b1; e_rdata = '0;
    chk("timeout_latency", 32'(cyc - s0), 32'd9);
    step();
    set_idle();
    i_wb_ack = 1'b1; i_wb_data = 32'h77777777;
    step();
    i_wb_ack = 1'b0;
    step();
    chk("timeout_single_resp", 32'(rv_cnt - r0), 32'd1);
`endif

    // Reset while in WAIT
    r0 = rv_cnt;
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h300; i_req_data = '0; i_req_funct3 = 3'b010;
    step();
    i_req_valid = 1'b0;
    e_wchk = 1'b1; e_we = 1'b0; e_addr = 32'h300; e_wdata = '0; e_sel = 3'b010;
    e_ready = 1'b0; e_stb = 1'b1;
    step();
    e_stb = 1'b0;
    step();
    i_reset = 1'b1;
    set_idle();
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_sel = '0;
    step();
    i_reset = 1'b0;
    i_wb_ack = 1'b1;
    step();
    i_wb_ack = 1'b0;
    step();
    step();
    chk("reset_no_resp", 32'(rv_cnt - r0), 32'd0);

    // Usable after reset
    run_txn(1'b0, 32'h500, 32'h0, 3'b000, 0, 1, 32'h0000007E, rc);
    chk("post_reset_latency", 32'(rc), 32'd3);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the Wishbone initiator that sits between the CPU execute stage and the `bus` interconnect. It accepts one memory request at a time from the core and checks address alignment. It drives a single-beat pipelined Wishbone transaction and holds `o_wb_stb` through slave stall. It returns read data or completion to the core with an error flag.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles from first `o_wb_stb` assertion to abort. Range 1..65535. Used only with `LSU_TIMEOUT_EN`.
- `i_clk` in 1: system clock, all logic on rising edge.
- `i_reset` in 1: reset, asynchronous, active-high.
- `i_req_valid` in 1: core request present.
- `i_req_we` in 1: 1 = store, 0 = load.
- `i_req_addr` in 32: byte address.
- `i_req_data` in 32: store data, right-aligned.
- `i_req_funct3` in 3: size code. 000 = byte, 001 = half, 010 = word, 100 = byte zero-extend, 101 = half zero-extend.
- `o_req_ready` out 1: request accepted when `i_req_valid && o_req_ready`.
- `o_resp_valid` out 1: one-cycle completion pulse.
- `o_resp_data` out 32: load data as returned by the slave. 0 on stores and errors.
- `o_resp_err` out 1: valid with `o_resp_valid`. Set on misalign, illegal size, or timeout.
- `o_wb_stb` out 1: Wishbone strobe.
- `o_wb_we` out 1: Wishbone write enable.
- `o_wb_addr` out 32: Wishbone address.
- `o_wb_data` out 32: Wishbone write data.
- `o_wb_sel` out 3: size code. Same encoding as `i_req_funct3`, passed through unchanged.
- `i_wb_data` in 32: slave read data.
- `i_wb_ack` in 1: slave acknowledge.
- `i_wb_stall` in 1: slave not accepting the strobe this cycle.

## Operation
- **States:** IDLE, REQ, WAIT, RESP.
- **IDLE:** `o_req_ready`=1. On accept:
  - If the request is legal, latch addr, data, we and funct3 into the `o_wb_*` registers and go to REQ.
  - If it is illegal, go to RESP with err=1 and no bus cycle.
- **Legality:**
  - Loads: 000 and 100 are legal at any address. 001 and 101 require `addr[0]`=0. 010 requires `addr[1:0]`=0.
  - Stores: only 000, 001 and 010 are legal, with the same alignment rules.
  - All other codes are illegal.
- **REQ:** `o_wb_stb`=1.
  - If `i_wb_stall`=1, stay in REQ with all `o_wb_*` stable.
  - If `i_wb_stall`=0, the strobe is accepted. If `i_wb_ack` is also 1 in that cycle, go to RESP. Otherwise go to WAIT.
- **WAIT:** `o_wb_stb`=0. On `i_wb_ack`, capture `i_wb_data` (loads only) and go to RESP.
- **RESP:** `o_resp_valid`=1 for exactly one cycle, then return to IDLE. `o_req_ready`=0.
- **Output stability:** `o_wb_addr`, `o_wb_data`, `o_wb_sel` and `o_wb_we` hold from accept until the next accept.
- **Acks outside a cycle:** `i_wb_ack` in IDLE or RESP is ignored.
- **Reset values:** all outputs 0 except `o_req_ready`=1 (IDLE). Reset mid-transaction aborts immediately, with no response pulse.

## Timing
- **Fastest path** (no stall, ack one cycle after the strobe is accepted):
  - Cycle 0: accept.
  - Cycle 1: `o_wb_stb`.
  - Cycle 2: ack.
  - Cycle 3: `o_resp_valid`.
  - Cycle 4: `o_req_ready`.
- **Same-cycle ack:** an ack in cycle 1 (together with the accepted strobe) gives `o_resp_valid` in cycle 2.
- **Illegal request:** accept in cycle 0, `o_resp_valid` with err in cycle 1.
- **Stall:** each stall cycle adds one cycle of latency.
- **Throughput:** at most one request per 3 cycles.

## Configuration
- **Macro:** `LSU_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the counter equals `TIMEOUT_CYCLES - 1` with no ack, `o_wb_stb` drops and the FSM goes to RESP with err=1 and data 0.
  - If the ack arrives in the same cycle as the timeout, the ack wins.
- **Undefined:** no counter. The LSU waits indefinitely in REQ/WAIT.

## Structure
- **`lsu_pkg`:**
  - Size-code constants: `SIZE_B`=000, `SIZE_H`=001, `SIZE_W`=010, `SIZE_BU`=100, `SIZE_HU`=101.
  - FSM state typedef.
- **Sub-module `lsu_align_check`:**
  - Combinational.
  - Inputs: funct3, `addr[1:0]`, we.
  - Output: legal.

## Test plan
- **Word load, no stall:** load `addr`=0x100, funct3=010; slave acks cycle 2 with 0xDEADBEEF. Expect `o_resp_valid` in cycle 3, data 0xDEADBEEF, err=0.
- **Stall hold:** store `addr`=0x204, data 0x12345678, funct3=010; `i_wb_stall` high for 3 cycles. Expect `o_wb_stb` high 4 cycles, addr/data stable, single response with err=0.
- **Misalign:** load half at 0x101, funct3=001. Expect no `o_wb_stb`, and `o_resp_valid` with err=1 in cycle 1. Also store funct3=100: expect err=1.
- **Same-cycle ack:** ack together with the accepted stb. Expect response in cycle 2 with no WAIT state, and `o_req_ready` back in cycle 3.
- **Timeout (`LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** never ack. Expect err=1 response 8 cycles after stb assertion, and a later stray ack ignored.
- **Reset mid-WAIT:** assert `i_reset` in WAIT. Expect all outputs 0, `o_req_ready`=1, and no `o_resp_valid`.
